// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS subset core with a single unified memory port.
// Each instruction is fetched and executed through a small FSM. Only one memory
// access is outstanding at a time, and there is no pipelining.
//
// Supported instructions: add, sub, and, or, slt, lw, sw, beq, addi, j.
// Any other opcode or funct ends execution in a terminal TRAP state.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-high
//   mem_req    access request, held until mem_ready
//   mem_we     1 = write, 0 = read (valid while mem_req)
//   mem_addr   word-aligned byte address
//   mem_wdata  store data (valid while mem_req & mem_we)
//   mem_rdata  read data, sampled in the cycle where mem_req & mem_ready
//   mem_ready  access accepted and completed this cycle
//   pc         architectural PC
//   trap       sticky flag: unsupported opcode or funct decoded
//
// state  | meaning
// FETCH  | read instruction at pc; on ready: IR <= rdata, pc <= pc+4
// DECODE | A/B <= rs/rt; ALUOut <= branch target; dispatch on opcode
// MEMADR | ALUOut <= A + sext(imm)
// MEMRD  | read at ALUOut; on ready: MDR <= rdata
// MEMWB  | rt <= MDR
// MEMWR  | write B to ALUOut; wait for ready
// RTEX   | ALUOut <= A op B
// RTWB   | rd <= ALUOut
// ADDIEX | ALUOut <= A + sext(imm)
// ADDIWB | rt <= ALUOut
// BEQ    | pc <= ALUOut if A == B
// JMP    | pc <= {pc[31:28], IR[25:0], 00}
// TRAP   | terminal until reset, no memory requests
module mips_multicycle #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        trap
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEX,
    S_RTWB, S_ADDIEX, S_ADDIWB, S_BEQ, S_JMP, S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                         OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_SLT = 6'h2A;

  state_t      state, state_nx;
  logic [31:0] ir, a, b, alu_out, mdr;
  logic [31:0] regs [32];
  logic [31:0] alu_res, imm_sext, rs_val, rt_val;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic        ready, funct_ok;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        unused_shamt;

  assign ready    = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'h0 : regs[rs];
  assign rt_val   = (rt == 5'd0) ? 32'h0 : regs[rt];
  assign unused_shamt = ^ir[10:6];
  assign trap     = (state == S_TRAP);

  assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);

  always_comb begin
    alu_res = 32'h0;
    case (funct)
      FN_ADD:  alu_res = a + b;
      FN_SUB:  alu_res = a - b;
      FN_AND:  alu_res = a & b;
      FN_OR:   alu_res = a | b;
      FN_SLT:  alu_res = {31'h0, $signed(a) < $signed(b)};
      default: alu_res = 32'h0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nx = funct_ok ? S_RTEX : S_TRAP;
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_BEQ:       state_nx = S_BEQ;
          OP_ADDI:      state_nx = S_ADDIEX;
          OP_J:         state_nx = S_JMP;
          default:      state_nx = S_TRAP;
        endcase
      end
      S_MEMADR: state_nx = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (ready) state_nx = S_MEMWB;
      S_MEMWR:  if (ready) state_nx = S_FETCH;
      S_RTEX:   state_nx = S_RTWB;
      S_ADDIEX: state_nx = S_ADDIWB;
      S_MEMWB, S_RTWB, S_ADDIWB, S_BEQ, S_JMP: state_nx = S_FETCH;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Outputs. The request is gated by reset because the async reset parks the
  // FSM in FETCH, and FETCH would otherwise request immediately.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = alu_out;
    mem_wdata = b;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_out;
    case (state)
      S_FETCH: begin mem_req = 1'b1; mem_addr = pc; end
      S_MEMRD: mem_req = 1'b1;
      S_MEMWR: begin mem_req = 1'b1; mem_we = 1'b1; end
      S_MEMWB: begin rf_we = 1'b1; rf_wdata = mdr; end
      S_RTWB:  begin rf_we = 1'b1; rf_waddr = rd; end
      S_ADDIWB: rf_we = 1'b1;
      default: ;
    endcase
    if (reset) begin
      mem_req = 1'b0;
      rf_we   = 1'b0;
    end
  end

  // Datapath registers. ALUOut holds the branch target between DECODE and BEQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= 32'h0;
      a       <= 32'h0;
      b       <= 32'h0;
      alu_out <= 32'h0;
      mdr     <= 32'h0;
    end else begin
      case (state)
        S_FETCH: if (ready) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        S_DECODE: begin
          a       <= rs_val;
          b       <= rt_val;
          alu_out <= pc + {imm_sext[29:0], 2'b00};
        end
        S_MEMADR, S_ADDIEX: alu_out <= a + imm_sext;
        S_MEMRD: if (ready) mdr <= mem_rdata;
        S_RTEX:  alu_out <= alu_res;
        S_BEQ:   if (a == b) pc <= alu_out;
        S_JMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  // Register file: contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (rf_we && (rf_waddr != 5'd0)) regs[rf_waddr] <= rf_wdata;
  end

endmodule

// File: tb/tb_mips_multicycle.sv
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0, we0, ready0 = 1'b0, trap0;
  logic [31:0] addr0, wdata0, pc0, rdata0 = 32'h0;
  logic        rst1 = 1'b1;
  logic        req1, we1, ready1 = 1'b0, trap1;
  logic [31:0] addr1, wdata1, pc1, rdata1 = 32'h0;

  always #5 clk = ~clk;

  mips_multicycle dut0 (
    .clk(clk), .reset(rst), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_rdata(rdata0), .mem_ready(ready0), .pc(pc0), .trap(trap0)
  );

  mips_multicycle #(.RESET_PC(32'h0000_0400)) dut1 (
    .clk(clk), .reset(rst1), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_ready(ready1), .pc(pc1), .trap(trap1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] f, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, f};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] j_ins(input logic [25:0] t);
    return {6'h02, t};
  endfunction
  function automatic logic [31:0] sext(input logic [15:0] x);
    return {{16{x[15]}}, x};
  endfunction

  localparam logic [31:0] TRAP_WORD = 32'hFC00_0000;

  // Memory responder for dut0, with random wait states
  typedef struct {
    logic [31:0] addr; logic we; logic [31:0] wdata;
    int waits; int cyc; logic [31:0] pc_after;
  } txn_t;
  txn_t        log_q[$];
  logic [31:0] mem [0:1023];
  int          cyc = 0;
  int          wait_max = 0;
  int          data_wait = -1;
  bit          pending = 0;
  bit          fix_pc = 0;
  int          wait_left, waits_used;
  logic [31:0] h_addr, h_wdata;
  logic        h_we;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    txn_t t;
    if (fix_pc && log_q.size() > 0) log_q[log_q.size()-1].pc_after = pc0;
    fix_pc = 0;
    ready0 = 1'b0;
    rdata0 = 32'hDEAD_BEEF;
    if (rst) pending = 0;
    else if (req0) begin
      if (!pending) begin
        pending = 1; h_addr = addr0; h_we = we0; h_wdata = wdata0; waits_used = 0;
        if (data_wait >= 0 && !we0 && addr0 >= 32'h200) wait_left = data_wait;
        else wait_left = int'($urandom_range(wait_max));
      end else begin
        chk("hold_addr", addr0, h_addr);
        chk("hold_we", {31'h0, we0}, {31'h0, h_we});
        if (h_we) chk("hold_wdata", wdata0, h_wdata);
      end
      if (wait_left == 0) begin
        ready0 = 1'b1;
        if (we0) mem[addr0[11:2]] = wdata0;
        else     rdata0 = mem[addr0[11:2]];
        t.addr = addr0; t.we = we0; t.wdata = wdata0; t.waits = waits_used;
        t.cyc = cyc; t.pc_after = 32'h0;
        log_q.push_back(t);
        fix_pc = 1;
        pending = 0;
      end else begin
        wait_left--;
        waits_used++;
      end
    end else if (pending) begin
      chk("req_dropped", 32'd0, 32'd1);
      pending = 0;
    end
  end

  // ISA-level reference model: expected access sequence and CPI per instruction
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; bit fetch; int cpi;} exp_t;
  exp_t        exp_q[$];
  logic [31:0] mmem [0:1023];
  logic [31:0] mreg [0:31];
  bit          m_trapped;

  task automatic push_exp(input logic [31:0] ad, input logic w, input logic [31:0] d,
                          input bit f, input int c);
    exp_t e;
    e.addr = ad; e.we = w; e.wdata = d; e.fetch = f; e.cpi = c;
    exp_q.push_back(e);
  endtask

  task automatic model_run(input int max_instr);
    logic [31:0] mpc, ir, npc, va, vb, ea, res;
    int fi, cpi;
    exp_q.delete();
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    for (int i = 0; i < 1024; i++) mmem[i] = mem[i];
    mpc = 32'h0;
    m_trapped = 0;
    for (int n = 0; n < max_instr && !m_trapped; n++) begin
      ir = mmem[mpc[11:2]];
      fi = exp_q.size();
      push_exp(mpc, 1'b0, 32'h0, 1, 0);
      npc = mpc + 32'd4;
      va = mreg[ir[25:21]];
      vb = mreg[ir[20:16]];
      ea = va + sext(ir[15:0]);
      cpi = 4;
      case (ir[31:26])
        6'h00: begin
          case (ir[5:0])
            6'h20: res = va + vb;
            6'h22: res = va - vb;
            6'h24: res = va & vb;
            6'h25: res = va | vb;
            6'h2A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
            default: m_trapped = 1;
          endcase
          if (!m_trapped && ir[15:11] != 0) mreg[ir[15:11]] = res;
        end
        6'h08: if (ir[20:16] != 0) mreg[ir[20:16]] = ea;
        6'h23: begin
          cpi = 5;
          push_exp(ea, 1'b0, 32'h0, 0, 0);
          if (ir[20:16] != 0) mreg[ir[20:16]] = mmem[ea[11:2]];
        end
        6'h2B: begin
          push_exp(ea, 1'b1, vb, 0, 0);
          mmem[ea[11:2]] = vb;
        end
        6'h04: begin cpi = 3; if (va == vb) npc = npc + (sext(ir[15:0]) << 2); end
        6'h02: begin cpi = 3; npc = {npc[31:28], ir[25:0], 2'b00}; end
        default: m_trapped = 1;
      endcase
      if (!m_trapped) exp_q[fi].cpi = cpi;
      mpc = npc;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = TRAP_WORD;
  endtask

  // Run program in mem on dut0 from reset and compare against the model.
  task automatic run_prog(input string tag, input int max_instr);
    int n, j, sum;
    model_run(max_instr);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 log_q.delete(); rst = 1'b0;
    n = 0;
    while (log_q.size() < exp_q.size() && n < 5000) begin
      @(posedge clk); n++;
    end
    if (log_q.size() < exp_q.size()) chk({tag, " timeout"}, log_q.size(), exp_q.size());
    if (m_trapped) begin
      repeat (10) @(posedge clk);
      chk({tag, " trap"}, {31'h0, trap0}, 32'd1);
      chk({tag, " no_extra_access"}, log_q.size(), exp_q.size());
    end
    @(negedge clk); #1;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s[%0d] addr", tag, i), log_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s[%0d] we", tag, i), {31'h0, log_q[i].we}, {31'h0, exp_q[i].we});
      if (exp_q[i].we) chk($sformatf("%s[%0d] wdata", tag, i), log_q[i].wdata, exp_q[i].wdata);
      if (exp_q[i].fetch && exp_q[i].cpi > 0) begin
        j = i + 1;
        while (j < exp_q.size() && !exp_q[j].fetch) j++;
        if (j < exp_q.size() && j < log_q.size()) begin
          sum = 0;
          for (int k = i + 1; k <= j; k++) sum += log_q[k].waits;
          chk($sformatf("%s[%0d] cycles", tag, i), log_q[j].cyc - log_q[i].cyc,
              exp_q[i].cpi + sum);
        end
      end
    end
  endtask

  typedef struct {
    string name; logic [5:0] op; logic [5:0] funct;
    logic [31:0] a; logic [31:0] b; logic [31:0] exp;
  } vec_t;
  vec_t vecs [13];

  task automatic gen_random(input int len);
    int k, off, mx;
    clear_mem();
    for (int i = 128; i < 256; i++) mem[i] = $urandom;
    for (int r = 1; r <= 7; r++) mem[r-1] = i_ins(6'h08, 5'd0, 5'(r), 16'($urandom));
    for (int i = 7; i < len - 1; i++) begin
      k = int'($urandom_range(9));
      case (k)
        0, 1, 2: begin
          case ($urandom_range(4))
            0: mem[i] = r_ins(6'h20, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
            1: mem[i] = r_ins(6'h22, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
            2: mem[i] = r_ins(6'h24, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
            3: mem[i] = r_ins(6'h25, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
            default: mem[i] = r_ins(6'h2A, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
          endcase
        end
        3, 4: mem[i] = i_ins(6'h08, 5'($urandom_range(7)), 5'($urandom_range(7)), 16'($urandom));
        6:    mem[i] = i_ins(6'h2B, 5'd0, 5'($urandom_range(7)), 16'(32'h200 + 4 * $urandom_range(31)));
        7: begin
          mx = len - 2 - i;
          off = int'($urandom_range(mx < 3 ? mx : 3));
          mem[i] = i_ins(6'h04, 5'($urandom_range(7)), 5'($urandom_range(7)), 16'(off));
        end
        8: mem[i] = j_ins(26'($urandom_range(len - 1, i + 1)));
        default: mem[i] = i_ins(6'h23, 5'd0, 5'($urandom_range(7)), 16'(32'h200 + 4 * $urandom_range(31)));
      endcase
    end
    mem[len-1] = i_ins(6'h04, 5'd0, 5'd0, 16'hFFFF);
  endtask

  bit write_done1 = 0;
  always @(posedge clk) if (req1 && we1 && ready1) write_done1 = 1;

  initial begin
    int n, hi;
    vecs[0]  = '{"add_wrap",   6'h00, 6'h20, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[1]  = '{"add_ovf",    6'h00, 6'h20, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[2]  = '{"sub_neg",    6'h00, 6'h22, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
    vecs[3]  = '{"sub_ovf",    6'h00, 6'h22, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF};
    vecs[4]  = '{"and",        6'h00, 6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
    vecs[5]  = '{"or",         6'h00, 6'h25, 32'hF0F0_0000, 32'h0F0F_1234, 32'hFFFF_1234};
    vecs[6]  = '{"slt_m1_1",   6'h00, 6'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[7]  = '{"slt_1_m1",   6'h00, 6'h2A, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{"slt_min",    6'h00, 6'h2A, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
    vecs[9]  = '{"slt_eq",     6'h00, 6'h2A, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000};
    vecs[10] = '{"addi_m1",    6'h08, 6'h00, 32'h0000_0005, 32'h0000_FFFF, 32'h0000_0004};
    vecs[11] = '{"addi_wrap",  6'h08, 6'h00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[12] = '{"addi_sext",  6'h08, 6'h00, 32'h0000_1234, 32'h0000_8000, 32'hFFFF_9234};

    // Reset state and trap behaviour
    clear_mem();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset pc", pc0, 32'h0);
    chk("reset trap", {31'h0, trap0}, 32'd0);
    chk("reset req", {31'h0, req0}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; log_q.delete();
    @(negedge clk); #1;
    chk("first fetch req", {31'h0, req0}, 32'd1);
    chk("first fetch addr", addr0, 32'h0);
    @(negedge clk); #1;
    chk("trap in decode", {31'h0, trap0}, 32'd0);
    chk("req in decode", {31'h0, req0}, 32'd0);
    @(negedge clk); #1;
    chk("trap after decode", {31'h0, trap0}, 32'd1);
    hi = 0;
    repeat (20) begin @(negedge clk); #1; if (req0) hi++; end
    chk("trap no req", hi, 0);
    chk("trap sticky", {31'h0, trap0}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #1;
    chk("trap cleared", {31'h0, trap0}, 32'd0);
    chk("pc after reset", pc0, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("refetch req", {31'h0, req0}, 32'd1);
    chk("refetch addr", addr0, 32'h0);
    chk("refetch we", {31'h0, we0}, 32'd0);

    // ALU/addi table
    for (int v = 0; v < 13; v++) begin
      clear_mem();
      mem[192] = vecs[v].a;
      mem[193] = vecs[v].b;
      mem[0] = i_ins(6'h23, 5'd0, 5'd1, 16'h0300);
      mem[1] = i_ins(6'h23, 5'd0, 5'd2, 16'h0304);
      if (vecs[v].op == 6'h08) mem[2] = i_ins(6'h08, 5'd1, 5'd3, vecs[v].b[15:0]);
      else                     mem[2] = r_ins(vecs[v].funct, 5'd3, 5'd1, 5'd2);
      mem[3] = i_ins(6'h2B, 5'd0, 5'd3, 16'h0308);
      run_prog(vecs[v].name, 20);
      if (log_q.size() > 6) chk({vecs[v].name, " result"}, log_q[6].wdata, vecs[v].exp);
      else chk({vecs[v].name, " missing sw"}, log_q.size(), 7);
    end

    // Register 0 discard
    clear_mem();
    mem[0] = i_ins(6'h08, 5'd0, 5'd0, 16'd9);
    mem[1] = r_ins(6'h20, 5'd4, 5'd0, 5'd0);
    mem[2] = i_ins(6'h2B, 5'd0, 5'd4, 16'h0308);
    run_prog("r0", 20);
    if (log_q.size() > 3) chk("r0 result", log_q[3].wdata, 32'h0);
    else chk("r0 missing sw", log_q.size(), 4);

    // addi/add/sw sequence
    clear_mem();
    mem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = i_ins(6'h08, 5'd0, 5'd2, 16'd7);
    mem[2] = r_ins(6'h20, 5'd3, 5'd1, 5'd2);
    mem[3] = i_ins(6'h2B, 5'd0, 5'd3, 16'h0010);
    run_prog("seq", 20);
    if (log_q.size() > 4) begin
      chk("seq sw addr", log_q[4].addr, 32'h10);
      chk("seq sw we", {31'h0, log_q[4].we}, 32'd1);
      chk("seq sw data", log_q[4].wdata, 32'd12);
      chk("seq pc after sw fetch", log_q[3].pc_after, 32'h10);
    end else chk("seq missing sw", log_q.size(), 5);

    // beq taken / not taken at 0x20
    clear_mem();
    mem[0] = j_ins(26'd8);
    mem[8] = i_ins(6'h04, 5'd1, 5'd1, 16'd2);
    run_prog("beq_t", 5);
    if (log_q.size() > 2) chk("beq taken target", log_q[2].addr, 32'h2C);
    else chk("beq_t short", log_q.size(), 3);
    clear_mem();
    mem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd1);
    mem[1] = j_ins(26'd8);
    mem[8] = i_ins(6'h04, 5'd1, 5'd0, 16'd2);
    run_prog("beq_nt", 6);
    if (log_q.size() > 3) chk("beq not taken", log_q[3].addr, 32'h24);
    else chk("beq_nt short", log_q.size(), 4);

    // lw with three wait cycles
    clear_mem();
    mem[192] = 32'hA5A5_1234;
    mem[0] = i_ins(6'h23, 5'd0, 5'd5, 16'h0300);
    mem[1] = i_ins(6'h2B, 5'd0, 5'd5, 16'h0308);
    data_wait = 3;
    run_prog("lw_wait", 3);
    data_wait = -1;
    if (log_q.size() > 3) begin
      chk("lw_wait waits", log_q[1].waits, 3);
      chk("lw_wait cycles", log_q[2].cyc - log_q[0].cyc, 8);
      chk("lw_wait data", log_q[3].wdata, 32'hA5A5_1234);
    end else chk("lw_wait short", log_q.size(), 4);

    // Random programs
    for (int r = 0; r < 6; r++) begin
      wait_max = r % 4;
      gen_random(48);
      run_prog($sformatf("rnd%0d", r), 120);
    end
    wait_max = 0;

    // Reset during MEMWR wait on dut1 (RESET_PC = 0x400)
    @(posedge clk); #1 rst1 = 1'b0;
    n = 0;
    while (!req1 && n < 10) begin @(negedge clk); #1; n++; end
    chk("d1 fetch req", {31'h0, req1}, 32'd1);
    chk("d1 fetch addr", addr1, 32'h400);
    rdata1 = i_ins(6'h2B, 5'd0, 5'd0, 16'h0500);
    @(negedge clk); ready1 = 1'b1;
    @(posedge clk); #1 ready1 = 1'b0;
    n = 0;
    while (!(req1 && we1) && n < 10) begin @(negedge clk); #1; n++; end
    chk("d1 memwr req", {31'h0, req1 & we1}, 32'd1);
    chk("d1 memwr addr", addr1, 32'h500);
    chk("d1 memwr data", wdata1, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b1;
    @(negedge clk); #1;
    chk("d1 req in reset", {31'h0, req1}, 32'd0);
    chk("d1 pc in reset", pc1, 32'h400);
    @(posedge clk); #1 rst1 = 1'b0;
    @(negedge clk); #1;
    chk("d1 no write", {31'h0, write_done1}, 32'd0);
    chk("d1 refetch req", {31'h0, req1}, 32'd1);
    chk("d1 refetch we", {31'h0, we1}, 32'd0);
    chk("d1 refetch addr", addr1, 32'h400);
    chk("d1 trap", {31'h0, trap1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
